// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: default sizing and derived widths shared by sync_fifo and its storage.
package sync_fifo_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH = 16;
  localparam int PTR_W = $clog2(DEF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: FIFO storage array with a synchronous write port and an asynchronous read-address port.
module sync_fifo_mem import sync_fifo_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data and count-derived full/empty flags.
// Define SYNC_FIFO_ERR_EN to add one-cycle overflow/underflow pulse outputs.
module sync_fifo import sync_fifo_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty
`ifdef SYNC_FIFO_ERR_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] count;
  logic [DATA_WIDTH-1:0] mem_data;
  logic wr_ok, rd_ok;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;
  sync_fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk,
    .we(wr_ok),
    .waddr(wp),
    .wdata(wr_data),
    .raddr(rp),
    .rdata(mem_data)
  );
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      rd_data <= '0;
    end else begin
      if (wr_ok) wp <= wp + 1'b1;
      if (rd_ok) begin
        rp <= rp + 1'b1;
        rd_data <= mem_data;
      end
      count <= count + CW'(wr_ok) - CW'(rd_ok);
    end
`ifdef SYNC_FIFO_ERR_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow <= wr_en && full;
      underflow <= rd_en && empty;
    end
`endif
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: queue-model scoreboard bench for sync_fifo with directed and random traffic.
module tb_sync_fifo;
  localparam int DEPTH = 16;
  logic clk = 1'b0, rst = 1'b1, wr_en = 1'b0, rd_en = 1'b0;
  logic [7:0] wr_data = '0, rd_data;
  logic full, empty;
  int checks = 0, passed = 0;
  logic [7:0] mq[$];
  logic [7:0] expq[$];
  logic [7:0] exp_hold = '0;
  logic rd_acc = 1'b0, exp_ovf = 1'b0, exp_unf = 1'b0;
`ifdef SYNC_FIFO_ERR_EN
  logic overflow, underflow;
`endif
  sync_fifo #(.DATA_WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .rd_en(rd_en),
    .wr_data(wr_data),
    .rd_data(rd_data),
    .full(full),
    .empty(empty)
`ifdef SYNC_FIFO_ERR_EN
    ,
    .overflow(overflow),
    .underflow(underflow)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  // reference model: a plain queue holding the words the FIFO should contain
  always @(posedge clk or posedge rst)
    if (rst) begin
      mq.delete();
      expq.delete();
      exp_hold = '0;
      rd_acc = 1'b0;
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
    end else begin
      automatic bit do_rd = rd_en && mq.size() > 0;
      automatic bit do_wr = wr_en && mq.size() < DEPTH;
      exp_ovf = wr_en && mq.size() == DEPTH;
      exp_unf = rd_en && mq.size() == 0;
      rd_acc = do_rd;
      if (do_rd) begin
        exp_hold = mq.pop_front();
        expq.push_back(exp_hold);
      end
      if (do_wr) mq.push_back(wr_data);
    end
  // monitor: compares DUT outputs against the model shortly after each edge
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (rd_acc) begin
        if (expq.size() == 0) chk("scoreboard_underrun", 32'd1, 32'd0);
        else chk("rd_data", {24'd0, rd_data}, {24'd0, expq.pop_front()});
      end else chk("rd_data_hold", {24'd0, rd_data}, {24'd0, exp_hold});
      chk("full", {31'd0, full}, {31'd0, mq.size() == DEPTH});
      chk("empty", {31'd0, empty}, {31'd0, mq.size() == 0});
`ifdef SYNC_FIFO_ERR_EN
      chk("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
      chk("underflow", {31'd0, underflow}, {31'd0, exp_unf});
`endif
    end
  end
  task automatic cyc(input logic w, input logic r, input logic [7:0] d);
    @(negedge clk);
    wr_en = w;
    rd_en = r;
    wr_data = d;
  endtask
  task automatic chk_reset();
    chk("rst_rd_data", {24'd0, rd_data}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
`ifdef SYNC_FIFO_ERR_EN
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_underflow", {31'd0, underflow}, 32'd0);
`endif
  endtask
  initial begin
    #13;
    chk_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) cyc(1'b1, 1'b0, 8'(i));
    cyc(1'b1, 1'b0, 8'hFF);
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'h30 + 8'(i));
    cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    // asynchronous reset away from any clock edge
    #2 rst = 1'b1;
    #1 chk_reset();
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b1, 1'b0, 8'hFF);
    cyc(1'b1, 1'b0, 8'hAB);
    cyc(1'b1, 1'b1, 8'hEB);
    cyc(1'b1, 1'b1, 8'h66);
    cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 8'h80 + 8'(i));
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 8'hC0 + 8'(i));
    for (int i = 0; i < 15; i++) cyc(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 1000; i++) begin
      automatic int bias = (i / 200) % 3;
      cyc($urandom_range(0, 3) < (bias == 1 ? 3 : 2),
          $urandom_range(0, 3) < (bias == 2 ? 3 : 2),
          8'($urandom));
      if (i == 500) begin
        #3 rst = 1'b1;
        #1 chk_reset();
        @(negedge clk);
        rst = 1'b0;
      end
    end
    cyc(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
